// File: rtl/vga_pkg.sv
// Shared VGA timing package for the character-buffer read side.
// Holds the 640x480@60 timing constants, character-cell geometry and the
// 12-bit colour type used by vga_char_scanner and vga_axis_counter.
package vga_pkg;

  // Counter width shared by the horizontal and vertical axes
  localparam int unsigned CNT_W = 10;

  // Horizontal timing, in pixel clocks
  localparam int unsigned H_ACTIVE_N = 640;
  localparam int unsigned H_FRONT_N  = 16;
  localparam int unsigned H_SYNC_N   = 96;
  localparam int unsigned H_BACK_N   = 48;
  localparam int unsigned H_TOTAL    = H_ACTIVE_N + H_FRONT_N + H_SYNC_N + H_BACK_N;

  // Vertical timing, in lines
  localparam int unsigned V_ACTIVE_N = 480;
  localparam int unsigned V_FRONT_N  = 10;
  localparam int unsigned V_SYNC_N   = 2;
  localparam int unsigned V_BACK_N   = 33;
  localparam int unsigned V_TOTAL    = V_ACTIVE_N + V_FRONT_N + V_SYNC_N + V_BACK_N;

  // Counter-width forms of the boundaries the datapath compares against
  localparam logic [CNT_W-1:0] H_ACTIVE     = CNT_W'(H_ACTIVE_N);
  localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_ACTIVE_N + H_FRONT_N);
  localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_ACTIVE_N + H_FRONT_N + H_SYNC_N - 1);
  localparam logic [CNT_W-1:0] V_ACTIVE     = CNT_W'(V_ACTIVE_N);
  localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_ACTIVE_N + V_FRONT_N);
  localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_ACTIVE_N + V_FRONT_N + V_SYNC_N - 1);

  // Character cell geometry: 8 pixels wide, 16 lines tall
  localparam int unsigned CELL_W  = 8;
  localparam int unsigned CELL_H  = 16;
  localparam int unsigned HOFF_W  = $clog2(CELL_W);   // 3
  localparam int unsigned VOFF_W  = $clog2(CELL_H);   // 4
  localparam int unsigned HCHAR_W = 7;
  localparam int unsigned VCHAR_W = 5;

  // Address driven while blanked; always outside any buffer grid
  localparam logic [HCHAR_W-1:0] HCHAR_BLANK = '1;
  localparam logic [VCHAR_W-1:0] VCHAR_BLANK = '1;

  // 12-bit colour as driven onto the 4-bit-per-channel DAC
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Inclusive range test used for the sync windows
  function automatic logic in_window(input logic [CNT_W-1:0] value,
                                     input logic [CNT_W-1:0] first,
                                     input logic [CNT_W-1:0] last);
    return (value >= first) && (value <= last);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the VGA raster: counts 0..p_total-1 while inc is high and
// flags the wrap so the next axis can advance.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned p_total = H_TOTAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(p_total - 1);

  // Wrap is combinational so the dependent axis advances on the same edge
  assign wrap = inc && (cnt == LAST);

  // Raster position register; synchronous reset back to the origin
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_char_scanner.sv
// Read-side master for the character buffer. Generates 640x480@60 timing
// from a 25 MHz pixel clock, drives the cell/offset read address and turns
// the buffer's one-cycle-latency lit/out-of-bounds reply into registered RGB
// and active-low sync.
//
// Pipeline:
//   stage 0 : raster counters, combinational read address
//   stage 1 : active/sync/frame flags delayed to meet the buffer reply
//   stage 2 : registered DAC outputs
//
// Build option: define VGA_CHAR_SCANNER_OOB_TINT_EN to paint in-bounds
// display pixels whose address falls outside the buffer with p_oob_rgb;
// otherwise they are black.
module vga_char_scanner
  import vga_pkg::*;
#(
  parameter logic [11:0] p_fg_rgb  = 12'hFFF,
  parameter logic [11:0] p_bg_rgb  = 12'h000,
  parameter logic [11:0] p_oob_rgb = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [HCHAR_W-1:0] read_hchar,
  output logic [VCHAR_W-1:0] read_vchar,
  output logic [HOFF_W-1:0]  read_hoffset,
  output logic [VOFF_W-1:0]  read_voffset,
  input  logic               read_lit,
  input  logic               out_of_bounds,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               frame_start
);

  localparam rgb12_t FG_RGB = rgb12_t'(p_fg_rgb);
  localparam rgb12_t BG_RGB = rgb12_t'(p_bg_rgb);
`ifdef VGA_CHAR_SCANNER_OOB_TINT_EN
  localparam rgb12_t OOB_RGB = rgb12_t'(p_oob_rgb);
`else
  // Tint compiled out: pixels past the buffer edge are black, and the
  // parameter stays referenced so instances overriding it remain clean.
  localparam rgb12_t OOB_RGB = rgb12_t'(p_oob_rgb & 12'h000);
`endif

  // ---------------------------------------------------------------------
  // Stage 0: raster counters
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;

  vga_axis_counter #(.p_total(H_TOTAL)) u_h_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (1'b1),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  vga_axis_counter #(.p_total(V_TOTAL)) u_v_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (h_wrap),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  // Raster is at (0,0) right after reset or right after the last pixel of a
  // frame; tracking that avoids a full 20-bit origin compare.
  logic at_origin;

  // Origin tracker, set by reset or by the end-of-frame wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      at_origin <= 1'b1;
    end else begin
      at_origin <= v_wrap;
    end
  end

  logic active_s0;
  logic hs_s0;
  logic vs_s0;

  assign active_s0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
  assign hs_s0     = in_window(h_cnt, H_SYNC_FIRST, H_SYNC_LAST);
  assign vs_s0     = in_window(v_cnt, V_SYNC_FIRST, V_SYNC_LAST);

  // Read address: cell and offset while active, a guaranteed-out-of-grid
  // cell while blanked so the buffer never aliases v_cnt >= 512 onto row 0
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and infers a latch.
    read_hchar   = HCHAR_BLANK;
    read_vchar   = VCHAR_BLANK;
    read_hoffset = '0;
    read_voffset = '0;
    if (active_s0) begin
      read_hchar   = h_cnt[CNT_W-1:HOFF_W];
      read_hoffset = h_cnt[HOFF_W-1:0];
      read_vchar   = v_cnt[VCHAR_W+VOFF_W-1:VOFF_W];
      read_voffset = v_cnt[VOFF_W-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: align raster flags with the buffer's reply
  // ---------------------------------------------------------------------
  logic valid_s1;
  logic active_s1;
  logic hs_s1;
  logic vs_s1;
  logic frame_s1;

  // Delay the stage-0 flags by one cycle to meet read_lit/out_of_bounds
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s1  <= 1'b0;
      active_s1 <= 1'b0;
      hs_s1     <= 1'b0;
      vs_s1     <= 1'b0;
      frame_s1  <= 1'b0;
    end else begin
      valid_s1  <= 1'b1;
      active_s1 <= active_s0;
      hs_s1     <= hs_s0;
      vs_s1     <= vs_s0;
      frame_s1  <= at_origin;
    end
  end

  // Colour for the pixel whose reply is arriving now
  rgb12_t pix_rgb;

  // Pick blank / out-of-bounds / lit / unlit colour for the returning pixel
  always_comb begin
    pix_rgb = '0;
    if (valid_s1 && active_s1) begin
      if (out_of_bounds) begin
        pix_rgb = OOB_RGB;
      end else if (read_lit) begin
        pix_rgb = FG_RGB;
      end else begin
        pix_rgb = BG_RGB;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: registered DAC pins
  // ---------------------------------------------------------------------
  rgb12_t rgb_q;

  // Output registers; sync is active low so idle/reset level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      rgb_q       <= pix_rgb;
      vga_hs      <= ~(valid_s1 & hs_s1);
      vga_vs      <= ~(valid_s1 & vs_s1);
      frame_start <= valid_s1 & frame_s1;
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule
